// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/write-back (master) and the multi-port register file (slave).
// Read addresses and read data are packed per port: port k sits at [k*W +: W].
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] RAddr;
  logic [NUM_RD*DATA_W-1:0] RData;
  logic                     RegWr;
  logic [ADDR_W-1:0]        RW;
  logic [DATA_W-1:0]        BusW;
  logic                     RegWr1;
  logic [ADDR_W-1:0]        RW1;
  logic [DATA_W-1:0]        BusW1;

  modport master (
    output RAddr, RegWr, RW, BusW, RegWr1, RW1, BusW1,
    input  RData
  );

  modport slave (
    input  RAddr, RegWr, RW, BusW, RegWr1, RW1, BusW1,
    output RData
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports and two write ports.
// Optional same-cycle write forwarding and an optional hardwired zero register.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1
) (
  input logic         Clk,
  input logic         Reset,
  regfile_mp_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic                     wr0_en_s;
  logic                     wr1_en_s;
  logic                     byp_en_s;
  logic [ADDR_W-1:0]        ra_s;
  logic [NUM_RD*DATA_W-1:0] rdata_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (HAS_ZERO != 0) && (a == ZERO_A);
  endfunction

  // Effective write enables: zero register drops writes, port 0 wins an address clash
  always_comb begin
    wr0_en_s = rf.RegWr && !is_zero(rf.RW);
    wr1_en_s = rf.RegWr1 && !is_zero(rf.RW1) && !(rf.RegWr && (rf.RW == rf.RW1));
    byp_en_s = (BYPASS != 0) && !Reset;
  end

  // Storage update: reset clears everything and masks both write ports
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_en_s) begin
        mem_r[rf.RW] <= rf.BusW;
      end
      if (wr1_en_s) begin
        mem_r[rf.RW1] <= rf.BusW1;
      end
    end
  end

  // Read ports: zero register first, then forwarding (port 0 before port 1), then storage
  always_comb begin
    rdata_s = {(NUM_RD*DATA_W){1'b0}};
    ra_s    = {ADDR_W{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s = rf.RAddr[k*ADDR_W +: ADDR_W];
      if (is_zero(ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (byp_en_s && wr0_en_s && (rf.RW == ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = rf.BusW;
      end else if (byp_en_s && rf.RegWr1 && (rf.RW1 == ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = rf.BusW1;
      end else begin
        rdata_s[k*DATA_W +: DATA_W] = mem_r[ra_s];
      end
    end
  end

  assign rf.RData = rdata_s;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven with identical stimulus and
// compared against an array-based reference of the register-file rules.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int ZI = 31;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) ifa ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) ifb ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4)) ifc ();

  // a: zero reg + bypass, b: zero reg, no bypass, c: no zero reg, bypass, 4 read ports
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .HAS_ZERO(1), .ZERO_IDX(ZI), .BYPASS(1))
    dut_a (.Clk(Clk), .Reset(Reset), .rf(ifa));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .HAS_ZERO(1), .ZERO_IDX(ZI), .BYPASS(0))
    dut_b (.Clk(Clk), .Reset(Reset), .rf(ifb));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .HAS_ZERO(0), .ZERO_IDX(ZI), .BYPASS(1))
    dut_c (.Clk(Clk), .Reset(Reset), .rf(ifc));

  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] ra [4];

  logic [DW-1:0] mem_z [DEPTH];
  logic [DW-1:0] mem_n [DEPTH];

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    ifa.RegWr = we0; ifa.RW = wa0; ifa.BusW = d0; ifa.RegWr1 = we1; ifa.RW1 = wa1; ifa.BusW1 = d1;
    ifb.RegWr = we0; ifb.RW = wa0; ifb.BusW = d0; ifb.RegWr1 = we1; ifb.RW1 = wa1; ifb.BusW1 = d1;
    ifc.RegWr = we0; ifc.RW = wa0; ifc.BusW = d0; ifc.RegWr1 = we1; ifc.RW1 = wa1; ifc.BusW1 = d1;
    ifa.RAddr = {ra[1], ra[0]};
    ifb.RAddr = {ra[1], ra[0]};
    ifc.RAddr = {ra[3], ra[2], ra[1], ra[0]};
    #1;
  endtask

  // Reference: what a read should return given the configuration and current inputs
  function automatic logic [DW-1:0] exp_rd(input bit hz, input bit byp, input logic [AW-1:0] a);
    bit zero_w0;
    if (hz && a == ZI) return '0;
    zero_w0 = hz && (wa0 == ZI);
    if (byp && !Reset) begin
      if (we0 && wa0 == a && !zero_w0) return d0;
      if (we1 && wa1 == a) return d1;
    end
    return hz ? mem_z[a] : mem_n[a];
  endfunction

  // Reference storage update at a clock edge: port 1 first so port 0 overwrites a clash
  task automatic model_edge();
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_z[i] = '0;
        mem_n[i] = '0;
      end
    end else begin
      if (we1) begin
        mem_n[wa1] = d1;
        if (wa1 != ZI) mem_z[wa1] = d1;
      end
      if (we0) begin
        mem_n[wa0] = d0;
        if (wa0 != ZI) mem_z[wa0] = d0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("a_rd%0d[%0d]", k, ra[k]), ifa.RData[k*DW +: DW], exp_rd(1'b1, 1'b1, ra[k]));
      check_eq($sformatf("b_rd%0d[%0d]", k, ra[k]), ifb.RData[k*DW +: DW], exp_rd(1'b1, 1'b0, ra[k]));
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("c_rd%0d[%0d]", k, ra[k]), ifc.RData[k*DW +: DW], exp_rd(1'b0, 1'b1, ra[k]));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); we0 = 1'b1; wa0 = a; d0 = d; apply(); tick();
    idle(); apply();
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra[0] = a0; ra[1] = a1; ra[2] = a1; ra[3] = a0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? AW'(ZI) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rd2('0, '0);
    @(negedge Clk);
    Reset = 1'b1; we0 = 1'b1; wa0 = 5'd1; d0 = 64'h1234; apply(); tick();
    Reset = 1'b0; idle(); apply();

    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(a); ra[2] = AW'(a); ra[3] = AW'(a);
      apply(); check_all();
      check_eq("rst_zero", ifc.RData[3*DW +: DW], 64'd0);
    end

    wr0(5'd2, 64'd3456);
    wr0(5'd19, 64'd6453);
    wr0(5'd31, 64'd6453);
    rd2(5'd31, 5'd19); apply(); check_all();
    check_eq("b_zero31", ifb.RData[0 +: DW], 64'd0);
    check_eq("b_r19", ifb.RData[DW +: DW], 64'd6453);
    rd2(5'd19, 5'd2); apply(); check_all();
    check_eq("b_r19b", ifb.RData[0 +: DW], 64'd6453);
    check_eq("b_r2", ifb.RData[DW +: DW], 64'd3456);

    idle(); we0 = 1'b1; wa0 = 5'd5; d0 = 64'h11; we1 = 1'b1; wa1 = 5'd6; d1 = 64'h22; apply(); tick();
    idle(); rd2(5'd5, 5'd6); apply(); check_all();
    check_eq("dual_r5", ifb.RData[0 +: DW], 64'h11);
    check_eq("dual_r6", ifb.RData[DW +: DW], 64'h22);
    idle(); we0 = 1'b1; wa0 = 5'd7; d0 = 64'hAA; we1 = 1'b1; wa1 = 5'd7; d1 = 64'hBB; apply(); tick();
    idle(); rd2(5'd7, 5'd7); apply(); check_all();
    check_eq("clash_r7", ifb.RData[0 +: DW], 64'hAA);

    rd2(5'd9, 5'd9);
    idle(); we0 = 1'b1; wa0 = 5'd9; d0 = 64'hDEAD; apply(); check_all();
    check_eq("byp_p0", ifa.RData[0 +: DW], 64'hDEAD);
    check_eq("nobyp_old", ifb.RData[0 +: DW], 64'd0);
    idle(); we1 = 1'b1; wa1 = 5'd9; d1 = 64'hBEEF; apply(); check_all();
    check_eq("byp_p1", ifa.RData[0 +: DW], 64'hBEEF);
    idle(); we0 = 1'b1; wa0 = 5'd9; d0 = 64'hDEAD; apply(); tick();
    idle(); apply(); check_all();
    check_eq("nobyp_new", ifb.RData[0 +: DW], 64'hDEAD);

    rd2(5'd31, 5'd31);
    idle(); we0 = 1'b1; wa0 = 5'd31; d0 = 64'hFFFF; apply(); check_all();
    check_eq("zero_pre", ifa.RData[0 +: DW], 64'd0);
    tick(); idle(); apply(); check_all();
    check_eq("zero_post", ifa.RData[0 +: DW], 64'd0);
    check_eq("nozero_post", ifc.RData[0 +: DW], 64'hFFFF);

    wr0(5'd3, 64'd77);
    rd2(5'd3, 5'd4);
    Reset = 1'b1; idle(); we0 = 1'b1; wa0 = 5'd4; d0 = 64'd99; apply(); check_all();
    check_eq("rst_stored", ifa.RData[0 +: DW], 64'd77);
    check_eq("rst_nobyp", ifa.RData[DW +: DW], 64'd0);
    tick();
    Reset = 1'b0; idle(); apply(); check_all();
    check_eq("rst_r3", ifa.RData[0 +: DW], 64'd0);
    check_eq("rst_r4", ifa.RData[DW +: DW], 64'd0);

    for (int n = 0; n < 600; n++) begin
      Reset = ($urandom_range(0, 19) == 0);
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = pick_addr();
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : pick_addr();
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) ra[k] = pick_addr();
      apply(); check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
